// File: rtl/ladybird_config.sv
// ladybird_config -- shared constants and types for the ladybird core buses.
//   ROUTER_BASE / ROUTER_MASK : default address map for ladybird_addr_router
//                               (port 0 IRAM, 1 BRAM, 2 DRAM, 3 UART, 4 QSPI, 5 GPIO)
//   rsp_t                     : bundled response {data, err, valid}
//   ACCESS_TYPE               : read/write access kind, kept for legacy users
package ladybird_config;

  localparam int ROUTER_NUM_PORT = 6;
  localparam int ROUTER_XLEN     = 32;

  localparam int PORT_IRAM = 0;
  localparam int PORT_BRAM = 1;
  localparam int PORT_DRAM = 2;
  localparam int PORT_UART = 3;
  localparam int PORT_QSPI = 4;
  localparam int PORT_GPIO = 5;

  typedef enum logic {
    ACCESS_READ  = 1'b0,
    ACCESS_WRITE = 1'b1
  } ACCESS_TYPE;

  typedef struct packed {
    logic [ROUTER_XLEN-1:0] data;
    logic                   err;
    logic                   valid;
  } rsp_t;

  // Top-nibble map. DRAM has no window of its own: a zero mask with a
  // non-zero base can never match, so DRAM is reached only as the default.
  localparam logic [ROUTER_NUM_PORT-1:0][ROUTER_XLEN-1:0] ROUTER_BASE = {
    32'hE000_0000,   // 5 GPIO
    32'hD000_0000,   // 4 QSPI
    32'hF000_0000,   // 3 UART
    32'hFFFF_FFFF,   // 2 DRAM (never matches)
    32'h8000_0000,   // 1 BRAM
    32'h9000_0000    // 0 IRAM
  };

  localparam logic [ROUTER_NUM_PORT-1:0][ROUTER_XLEN-1:0] ROUTER_MASK = {
    32'hF000_0000,
    32'hF000_0000,
    32'hF000_0000,
    32'h0000_0000,
    32'hF000_0000,
    32'hF000_0000
  };

  // Strobe-to-access-kind helper for legacy code paths.
  function automatic ACCESS_TYPE access_of(input logic [ROUTER_XLEN/8-1:0] wstrb);
    return (|wstrb) ? ACCESS_WRITE : ACCESS_READ;
  endfunction

endpackage

// File: rtl/ladybird_addr_router_decode.sv
// ladybird_addr_decode -- combinational base/mask priority address decoder.
//   addr : byte address to decode
//   hit  : at least one port window matches
//   idx  : lowest matching port index (0 when no hit)
module ladybird_addr_decode
  import ladybird_config::*;
#(
  parameter int NUM_PORT = 6,
  parameter int XLEN     = 32,
  parameter int IDX_W    = 3,
  parameter logic [NUM_PORT-1:0][XLEN-1:0] PORT_BASE = '0,
  parameter logic [NUM_PORT-1:0][XLEN-1:0] PORT_MASK = '0
) (
  input  logic [XLEN-1:0]  addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [NUM_PORT-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_match
      assign match[gi] = ((addr & PORT_MASK[gi]) == PORT_BASE[gi]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the one left.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ladybird_addr_router.sv
// ladybird_addr_router -- 1-to-N in-order request router for a ladybird core bus.
//   clk, reset                 : clock, synchronous active-high reset
//   up_req_* / up_rsp_*        : core-side request (valid/ready) and response (valid only)
//   dn_req_valid / dn_req_ready: one-hot per-port request handshake
//   dn_req_addr/wdata/wstrb    : request payload broadcast to every port
//   dn_rsp_valid/data/err      : per-port responses (data flattened, port i at [i*XLEN +: XLEN])
//   spurious                   : high in any cycle a downstream response is dropped
// Requests only go to one target at a time; a switch waits until every
// in-flight response has returned, which keeps responses in request order.
module ladybird_addr_router
  import ladybird_config::*;
#(
  parameter int NUM_PORT        = 6,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_PORT-1:0][XLEN-1:0] PORT_BASE = ladybird_config::ROUTER_BASE,
  parameter logic [NUM_PORT-1:0][XLEN-1:0] PORT_MASK = ladybird_config::ROUTER_MASK,
  parameter int DEFAULT_PORT    = 2,
  parameter int ERR_ON_MISS     = 0
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     up_req_valid,
  output logic                     up_req_ready,
  input  logic [XLEN-1:0]          up_req_addr,
  input  logic [XLEN-1:0]          up_req_wdata,
  input  logic [XLEN/8-1:0]        up_req_wstrb,
  output logic                     up_rsp_valid,
  output logic [XLEN-1:0]          up_rsp_data,
  output logic                     up_rsp_err,

  output logic [NUM_PORT-1:0]      dn_req_valid,
  input  logic [NUM_PORT-1:0]      dn_req_ready,
  output logic [XLEN-1:0]          dn_req_addr,
  output logic [XLEN-1:0]          dn_req_wdata,
  output logic [XLEN/8-1:0]        dn_req_wstrb,
  input  logic [NUM_PORT-1:0]      dn_rsp_valid,
  input  logic [NUM_PORT*XLEN-1:0] dn_rsp_data,
  input  logic [NUM_PORT-1:0]      dn_rsp_err,

  output logic                     spurious
);

  // Target index NUM_PORT is the internal MISS responder.
  localparam int TGT_W = $clog2(NUM_PORT + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TGT_W-1:0] MISS     = TGT_W'(NUM_PORT);
  localparam logic [TGT_W-1:0] DEF_TGT  = TGT_W'(DEFAULT_PORT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [TGT_W-1:0] cur_tgt_reg, cur_tgt_next;
  logic [CNT_W-1:0] miss_pend_reg, miss_pend_next;

  logic             dec_hit;
  logic [TGT_W-1:0] dec_idx;
  logic [TGT_W-1:0] dec_tgt;
  logic             tgt_ready;
  logic             stall;
  logic             blocked;
  logic             accept;
  logic             busy;
  logic             cur_is_miss;
  logic             miss_pop;
  logic             rsp_fire;
  logic             sel_valid;
  logic             sel_err;
  logic [XLEN-1:0]  sel_data;
  logic [NUM_PORT-1:0] rsp_expected;
  logic [XLEN-1:0]  rsp_data_arr [NUM_PORT];

  // ---------------------------------------------------------------- decode
  ladybird_addr_decode #(
    .NUM_PORT  (NUM_PORT),
    .XLEN      (XLEN),
    .IDX_W     (TGT_W),
    .PORT_BASE (PORT_BASE),
    .PORT_MASK (PORT_MASK)
  ) u_decode (
    .addr (up_req_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign dec_tgt = dec_hit ? dec_idx : ((ERR_ON_MISS != 0) ? MISS : DEF_TGT);

  // ---------------------------------------------------------------- issue
  always_comb begin
    tgt_ready = (dec_tgt == MISS);
    for (int i = 0; i < NUM_PORT; i++) begin
      if (dec_tgt == TGT_W'(i)) tgt_ready = dn_req_ready[i];
    end
  end

  assign busy        = (cnt_reg != '0);
  assign stall       = (cnt_reg == CNT_FULL) || (busy && (dec_tgt != cur_tgt_reg));
  assign blocked     = stall | reset;
  assign up_req_ready = ~blocked & tgt_ready;
  assign accept      = up_req_valid & up_req_ready;

  assign dn_req_addr  = up_req_addr;
  assign dn_req_wdata = up_req_wdata;
  assign dn_req_wstrb = up_req_wstrb;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_port
      assign dn_req_valid[gi] = up_req_valid & ~blocked & (dec_tgt == TGT_W'(gi));
      assign rsp_data_arr[gi] = dn_rsp_data[gi*XLEN +: XLEN];
      // Only the port currently owning the in-flight window may respond.
      assign rsp_expected[gi] = busy & (cur_tgt_reg == TGT_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------- response
  always_comb begin
    sel_valid = 1'b0;
    sel_err   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (cur_tgt_reg == TGT_W'(i)) begin
        sel_valid = dn_rsp_valid[i];
        sel_err   = dn_rsp_err[i];
        sel_data  = rsp_data_arr[i];
      end
    end
  end

  assign cur_is_miss = (cur_tgt_reg == MISS);
  // MISS answers come from the pending count, one per cycle starting the
  // cycle after acceptance.
  assign miss_pop    = (miss_pend_reg != '0);
  assign rsp_fire    = busy & (cur_is_miss ? miss_pop : sel_valid);

  assign up_rsp_valid = ~reset & rsp_fire;
  assign up_rsp_data  = (~reset & busy & ~cur_is_miss) ? sel_data : '0;
  assign up_rsp_err   = ~reset & busy & (cur_is_miss ? miss_pop : sel_err);
  assign spurious     = ~reset & (|(dn_rsp_valid & ~rsp_expected));

  // ---------------------------------------------------------------- state
  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !rsp_fire)      cnt_next = cnt_reg + CNT_ONE;
    else if (!accept && rsp_fire) cnt_next = cnt_reg - CNT_ONE;

    cur_tgt_next = accept ? dec_tgt : cur_tgt_reg;

    miss_pend_next = miss_pend_reg;
    if ((accept && (dec_tgt == MISS)) && !miss_pop)      miss_pend_next = miss_pend_reg + CNT_ONE;
    else if (!(accept && (dec_tgt == MISS)) && miss_pop) miss_pend_next = miss_pend_reg - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      cur_tgt_reg   <= '0;
      miss_pend_reg <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      cur_tgt_reg   <= cur_tgt_next;
      miss_pend_reg <= miss_pend_next;
    end
  end

endmodule

// File: doc/ladybird_addr_router.md
# ladybird_addr_router

Parametrised 1-to-N request router between a ladybird core bus (I_BUS or D_BUS) and its peripherals. It replaces the fixed 4-bit address-nibble decode with a per-port base/mask map and a configurable default or decode-error path. It also tracks outstanding transactions, so responses return to the core in request order. One instance sits on each core bus, in front of the IRAM/BRAM/DRAM/UART/QSPI/GPIO targets.

## Interface
Parameters:
- NUM_PORT, 6, number of downstream targets (1..16).
- XLEN, 32, address/data width.
- MAX_OUTSTANDING, 4, maximum in-flight requests (power of two, ≥1).
- PORT_BASE, ladybird_config::ROUTER_BASE, packed array [NUM_PORT][XLEN]; per-port base address.
- PORT_MASK, ladybird_config::ROUTER_MASK, packed array [NUM_PORT][XLEN]; per-port compare mask.
- DEFAULT_PORT, 2 (DRAM), target for unmatched addresses when ERR_ON_MISS=0.
- ERR_ON_MISS, 0, 1 = unmatched requests are answered internally with an error.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- up_req_valid  in  1  request valid.
- up_req_ready  out  1  request accepted when valid&ready.
- up_req_addr  in  XLEN  byte address.
- up_req_wdata  in  XLEN  write data.
- up_req_wstrb  in  XLEN/8  byte strobes; all-zero = read.
- up_rsp_valid  out  1  response valid (no backpressure).
- up_rsp_data  out  XLEN  read data.
- up_rsp_err  out  1  bus error.
- dn_req_valid  out  NUM_PORT  one-hot request valid.
- dn_req_ready  in  NUM_PORT  per-port ready.
- dn_req_addr/wdata/wstrb  out  XLEN/XLEN/XLEN/8  broadcast to all ports.
- dn_rsp_valid  in  NUM_PORT  per-port response valid.
- dn_rsp_data  in  NUM_PORT*XLEN  per-port read data.
- dn_rsp_err  in  NUM_PORT  per-port error.
- spurious  out  1  one-cycle pulse on an unexpected downstream response.

## Operation
- Decode: port i matches when (addr & PORT_MASK[i]) == PORT_BASE[i]. Lowest matching index wins.
- No match: the request goes to DEFAULT_PORT, or to the virtual MISS target when ERR_ON_MISS=1.
- State: cnt (0..MAX_OUTSTANDING) and cur_tgt (index of the in-flight target, or MISS).
- Issue rule: a request may issue only when cnt < MAX_OUTSTANDING and either cnt==0 or the decoded target == cur_tgt. Otherwise up_req_ready=0 and all dn_req_valid=0 (stall).
- Passing a request to a port: dn_req_valid[t] = up_req_valid & ~stall; up_req_ready = dn_req_ready[t] & ~stall.
- MISS target: always ready. Each accepted MISS request queues one error response (pending counter ≤ MAX_OUTSTANDING).
- Accept: cnt++ and cur_tgt <= target. Response from cur_tgt: cnt--. Both in the same cycle: cnt is unchanged.
- Response mux:
  - up_rsp_* = dn_rsp_*[cur_tgt] when cnt>0.
  - MISS responses drive up_rsp_valid=1, data=0, err=1.
- dn_rsp_valid from a port ≠ cur_tgt, or any dn_rsp_valid while cnt==0: the response is dropped and spurious pulses for one cycle. The counter is unaffected.

## Timing
- Request path is combinational (0-cycle). dn_rsp→up_rsp is combinational.
- MISS error response appears exactly 1 cycle after acceptance, one per cycle in order.
- Reset values: cnt=0, cur_tgt=0, MISS pending=0, up_rsp_valid=0, up_rsp_err=0, up_rsp_data=0, spurious=0.
  - Combinationally: up_req_ready=0 and dn_req_valid=0 while reset=1.
- Reset mid-transaction: in-flight requests are forgotten. Responses arriving after reset flag spurious.
- Full: cnt==MAX_OUTSTANDING blocks issue. An accept and a response in the same cycle at full is impossible, because ready=0.
- Target switch: first request to a new target issues in the cycle after the last old response (cnt reaches 0).

## Structure
- ladybird_config gains:
  - ROUTER_BASE and ROUTER_MASK localparams encoding the current map: F→UART, E→GPIO, D→QSPI, 8→BRAM, 9→IRAM, mask F000_0000.
  - A rsp_t struct {data, err, valid}.
  - ACCESS_TYPE is kept for legacy users.
- Sub-module ladybird_addr_decode: combinational base/mask priority match producing target index and hit flag. Everything sequential stays in ladybird_addr_router.

## Test plan
- Read 0xF000_0010, UART (port 3) ready → dn_req_valid=6'b001000 in the same cycle. Response data 0x41 → up_rsp_data=0x41, err=0, cnt back to 0.
- Four back-to-back reads to 0x8000_0000.. with BRAM response withheld → 4 accepted, fifth up_req_ready=0. Returning one response frees one slot in the next cycle.
- BRAM read in flight, then GPIO request 0xE000_0000 → stalled until the BRAM response. GPIO issues in the following cycle.
- ERR_ON_MISS=1, address 0x1000_0000 → ready=1, error response next cycle with err=1, data=0. With ERR_ON_MISS=0 the same address routes to DRAM (port 2).
- dn_rsp_valid[5] asserted with cnt=0 → spurious=1 for one cycle, up_rsp_valid=0.
- reset asserted with cnt=3 → cnt=0, up_req_ready=0 during reset. Post-reset stale response → spurious pulse.
